// File: rtl/com_uart_pkg.sv
// Shared types for the UART transmit path: sequencer states and the
// baud-rate select encodes with their default bit periods.
package com_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    typedef enum logic [2:0] {
        BAUD_4800     = 3'd0,
        BAUD_9600     = 3'd1,
        BAUD_19200    = 3'd2,
        BAUD_38400    = 3'd3,
        BAUD_57600    = 3'd4,
        BAUD_115200   = 3'd5,
        BAUD_UNIQUE_1 = 3'd6,
        BAUD_UNIQUE_2 = 3'd7
    } baud_sel_e;

    localparam int unsigned BAUD_REF_CLK_HZ = 32'd50_000_000;

    // Default bit_period for each select at the 50 MHz reference clock.
    function automatic logic [15:0] baud_default_period(input baud_sel_e sel);
        logic [15:0] period;
        case (sel)
            BAUD_4800:     period = 16'd10417;
            BAUD_9600:     period = 16'd5208;
            BAUD_19200:    period = 16'd2604;
            BAUD_38400:    period = 16'd1302;
            BAUD_57600:    period = 16'd868;
            BAUD_115200:   period = 16'd434;
            BAUD_UNIQUE_1: period = 16'd217;
            BAUD_UNIQUE_2: period = 16'd109;
            default:       period = 16'd434;
        endcase
        return period;
    endfunction

endpackage

// File: rtl/com_uart_baud_tick.sv
// Bit-time divider: latches the bit period at frame load and pulses
// bit_end on the last clock of every bit while enabled.
module com_uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] bit_period,
    output logic                 bit_end
);

    localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(2);

    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign bit_end = enable && (cnt_q == (period_q - DIV_WIDTH'(1)));

    // Next period/count: clear reloads the period (floored at 2) and restarts the phase.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        if (clear) begin
            if (bit_period < MIN_PERIOD) begin
                period_d = MIN_PERIOD;
            end else begin
                period_d = bit_period;
            end
            cnt_d = '0;
        end else if (enable) begin
            if (bit_end) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Period latch and tick counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= MIN_PERIOD;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/com_uart_trans_ctrl.sv
// UART transmit sequencer: pops one byte per frame from the TX FIFO and
// shifts start, data (LSB first), optional parity and stop bits onto tx.
module com_uart_trans_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  bit_period,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  ctrl_idle_state,
    output logic                  ctrl_stop_state,
    output logic                  tx_busy,
    output logic                  tx_complete
);

    import com_uart_pkg::*;

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_INIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  idle_q, idle_d;
    logic                  stop_q, stop_d;
    logic                  busy_q, busy_d;

    logic tick_clear_s;
    logic tick_en_s;
    logic bit_end_s;

    assign tick_clear_s = (state_q == ST_POP);
    assign tick_en_s    = (state_q == ST_START) || (state_q == ST_DATA) ||
                          (state_q == ST_PARITY) || (state_q == ST_STOP);

    com_uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk        (clk),
        .rst        (rst),
        .clear      (tick_clear_s),
        .enable     (tick_en_s),
        .bit_period (bit_period),
        .bit_end    (bit_end_s)
    );

    // The pop strobe is qualified by rst so no byte is lost while reset is held.
    assign fifo_rd_en  = (state_q == ST_IDLE) && !fifo_empty && !rst;
    assign tx          = tx_q;
    assign ctrl_idle_state = idle_q;
    assign ctrl_stop_state = stop_q;
    assign tx_busy     = busy_q;
    assign tx_complete = fifo_empty && idle_q;

    // Next-state logic; tx_d is the level of the bit being entered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        tx_d      = tx_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
                tx_d = 1'b1;
            end
            ST_POP: begin
                state_d   = ST_START;
                shift_d   = fifo_data;
                par_d     = PAR_INIT;
                bit_idx_d = '0;
                tx_d      = 1'b0;
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q ^ shift_q[0];
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_d[0];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                // bit_idx counts stop bits here so 2-stop frames reuse the same tick.
                if (bit_end_s) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_STOP;
                end
                tx_d = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                tx_d      = 1'b1;
            end
        endcase
        idle_d = (state_d == ST_IDLE);
        stop_d = (state_d == ST_STOP);
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            idle_q    <= 1'b1;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            idle_q    <= idle_d;
            stop_q    <= stop_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_com_uart_trans_ctrl.sv
// Directed bench for com_uart_trans_ctrl: three instances (8N1, even parity
// with 2 stop bits, odd parity) fed from small behavioural FIFOs.
module tb_com_uart_trans_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bit_period;

    logic [2:0] fifo_empty_v;
    logic [2:0] rd_en_v;
    logic [2:0] tx_v;
    logic [2:0] idle_v;
    logic [2:0] stop_v;
    logic [2:0] busy_v;
    logic [2:0] cpl_v;
    logic [7:0] fifo_data_v [3];

    logic [7:0] mem [3][16];
    int         wr_cnt [3] = '{0, 0, 0};
    int         rd_cnt [3] = '{0, 0, 0};
    logic [2:0] bad_pop = 3'b000;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   gap;
    logic cpl;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        assign fifo_empty_v[g] = (rd_cnt[g] == wr_cnt[g]);
    end

    // FIFO read side: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en_v[k]) begin
                fifo_data_v[k] <= mem[k][rd_cnt[k] & 15];
                rd_cnt[k]      <= rd_cnt[k] + 1;
                if (fifo_empty_v[k]) bad_pop[k] <= 1'b1;
            end
        end
    end

    com_uart_trans_ctrl u_dut_8n1 (
        .clk             (clk),
        .rst             (rst),
        .bit_period      (bit_period),
        .fifo_empty      (fifo_empty_v[0]),
        .fifo_data       (fifo_data_v[0]),
        .fifo_rd_en      (rd_en_v[0]),
        .tx              (tx_v[0]),
        .ctrl_idle_state (idle_v[0]),
        .ctrl_stop_state (stop_v[0]),
        .tx_busy         (busy_v[0]),
        .tx_complete     (cpl_v[0])
    );

    com_uart_trans_ctrl #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_8e2 (
        .clk             (clk),
        .rst             (rst),
        .bit_period      (bit_period),
        .fifo_empty      (fifo_empty_v[1]),
        .fifo_data       (fifo_data_v[1]),
        .fifo_rd_en      (rd_en_v[1]),
        .tx              (tx_v[1]),
        .ctrl_idle_state (idle_v[1]),
        .ctrl_stop_state (stop_v[1]),
        .tx_busy         (busy_v[1]),
        .tx_complete     (cpl_v[1])
    );

    com_uart_trans_ctrl #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut_8o1 (
        .clk             (clk),
        .rst             (rst),
        .bit_period      (bit_period),
        .fifo_empty      (fifo_empty_v[2]),
        .fifo_data       (fifo_data_v[2]),
        .fifo_rd_en      (rd_en_v[2]),
        .tx              (tx_v[2]),
        .ctrl_idle_state (idle_v[2]),
        .ctrl_stop_state (stop_v[2]),
        .tx_busy         (busy_v[2]),
        .tx_complete     (cpl_v[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wr_cnt[k] & 15] = b;
        wr_cnt[k] = wr_cnt[k] + 1;
    endtask

    // Waits (bounded) for the first start-bit cycle; gap counts the high cycles before it.
    task automatic wait_start(input int k, input string tag, output int gap_o);
        gap_o = 0;
        while (tx_v[k] !== 1'b0 && gap_o < 400) begin
            gap_o++;
            @(negedge clk);
        end
        check_eq({tag, "_start"}, 32'(tx_v[k]), 32'd0);
    endtask

    // Checks every cycle of a frame against exp_bits (bit i = i-th bit on the line).
    task automatic run_frame(input int k, input int period, input int nbits, input int nstop,
                             input logic [15:0] exp_bits, input string tag,
                             output int gap_o, output logic last_cpl);
        int errs;
        int stop_cyc;
        errs     = 0;
        stop_cyc = 0;
        last_cpl = 1'b0;
        wait_start(k, tag, gap_o);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < period; c++) begin
                if (tx_v[k] !== exp_bits[i]) errs++;
                if (busy_v[k] !== 1'b1) errs++;
                if (stop_v[k] === 1'b1) stop_cyc++;
                last_cpl = cpl_v[k];
                @(negedge clk);
            end
        end
        check_eq({tag, "_bits"}, 32'(errs), 32'd0);
        check_eq({tag, "_stop_len"}, 32'(stop_cyc), 32'(nstop * period));
        check_eq({tag, "_idle_after"}, 32'(idle_v[k]), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        bit_period = 16'd4;
        push(0, 8'hA5);

        // Reset held with a non-empty FIFO.
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx_v[0]), 32'd1);
        check_eq("rst_rd_en", 32'(rd_en_v[0]), 32'd0);
        check_eq("rst_idle", 32'(idle_v[0]), 32'd1);
        check_eq("rst_stop", 32'(stop_v[0]), 32'd0);
        check_eq("rst_busy", 32'(busy_v[0]), 32'd0);
        check_eq("rst_tx_complete", 32'(cpl_v[0]), 32'd0);
        rst = 1'b0;

        // 0xA5, 8N1, 4 cycles per bit.
        run_frame(0, 4, 10, 1, {6'd0, 1'b1, 8'hA5, 1'b0}, "a5_8n1", gap, cpl);
        check_eq("a5_8n1_gap", 32'(gap), 32'd2);
        check_eq("a5_8n1_pops", 32'(rd_cnt[0]), 32'd1);

        // Parity: even 0xA5 -> 0, odd 0x01 -> 0, even 0x07 -> 1.
        push(1, 8'hA5);
        run_frame(1, 4, 12, 2, {4'd0, 2'b11, 1'b0, 8'hA5, 1'b0}, "a5_8e2", gap, cpl);
        push(2, 8'h01);
        run_frame(2, 4, 11, 1, {5'd0, 1'b1, 1'b0, 8'h01, 1'b0}, "01_8o1", gap, cpl);
        push(1, 8'h07);
        run_frame(1, 4, 12, 2, {4'd0, 2'b11, 1'b1, 8'h07, 1'b0}, "07_8e2", gap, cpl);

        // Back-to-back 0x55, 0x0F with 2 stop bits at 3 cycles per bit.
        bit_period = 16'd3;
        push(1, 8'h55);
        push(1, 8'h0F);
        run_frame(1, 3, 12, 2, {4'd0, 2'b11, 1'b0, 8'h55, 1'b0}, "55_8e2", gap, cpl);
        check_eq("b2b_cpl_between", 32'(cpl_v[1]), 32'd0);
        run_frame(1, 3, 12, 2, {4'd0, 2'b11, 1'b0, 8'h0F, 1'b0}, "0f_8e2", gap, cpl);
        check_eq("b2b_gap", 32'(gap), 32'd2);
        check_eq("b2b_cpl_in_stop", 32'(cpl), 32'd0);
        check_eq("b2b_cpl_at_idle", 32'(cpl_v[1]), 32'd1);
        check_eq("b2b_pops", 32'(rd_cnt[1]), 32'd4);

        // bit_period 4 -> 8 while the first frame is in DATA.
        bit_period = 16'd4;
        push(0, 8'h3C);
        push(0, 8'hC3);
        fork
            run_frame(0, 4, 10, 1, {6'd0, 1'b1, 8'h3C, 1'b0}, "3c_p4", gap, cpl);
            begin
                repeat (10) @(negedge clk);
                bit_period = 16'd8;
            end
        join
        run_frame(0, 8, 10, 1, {6'd0, 1'b1, 8'hC3, 1'b0}, "c3_p8", gap, cpl);
        check_eq("c3_p8_gap", 32'(gap), 32'd2);

        // Reset during DATA bit 3 of 0x96 (bit 3 = 0).
        bit_period = 16'd4;
        push(0, 8'h96);
        wait_start(0, "96_abort", gap);
        repeat (17) @(negedge clk);
        check_eq("96_bit3_before_rst", 32'(tx_v[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_tx", 32'(tx_v[0]), 32'd1);
        check_eq("abort_idle", 32'(idle_v[0]), 32'd1);
        check_eq("abort_busy", 32'(busy_v[0]), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("abort_no_extra_pop", 32'(rd_cnt[0]), 32'd4);
        check_eq("abort_tx_complete", 32'(cpl_v[0]), 32'd1);

        // bit_period of 0 is floored to 2-cycle bits.
        bit_period = 16'd0;
        push(0, 8'h5A);
        run_frame(0, 2, 10, 1, {6'd0, 1'b1, 8'h5A, 1'b0}, "5a_p0", gap, cpl);

        check_eq("no_pop_when_empty", 32'(bad_pop), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
